lsu_ram_master: RTL and testbench

LSU_RAM_MASTER -- requirements
Module: lsu_ram_master

---
 rtl/lsu_ram_master.sv | 195 +++++++++++++++++++
 tb/tb_lsu_ram_master.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ram_master.sv
// Load/store unit front end for a single-port 32-bit word RAM with combinational read.
// Sub-word stores are done as read-modify-write; every request ends in a one-cycle response.
//
// state | meaning
// IDLE  | ready for a request; the request is checked and registered on acceptance
// RD    | RAM read at the registered word address (load data or RMW base word)
// WR    | RAM write of the full word (SW data or merged sub-word)
// RESP  | one-cycle response pulse, then back to IDLE
module lsu_ram_master #(
  parameter int RAM_DEPTH = 512,
  parameter int ADDR_W    = $clog2(RAM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] ram_address_o,
  output logic [31:0]       ram_data_o,
  output logic              ram_we_o,
  input  logic [31:0]       ram_data_i
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [1:0]          lo_q, lo_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [31:0]         ram_data_q, ram_data_d;
  logic                ram_we_q, ram_we_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;

  logic                req_err;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         load_ext;
  logic [31:0]         merged;

  always_comb begin
    req_err = 1'b0;
    if ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0])
      req_err = 1'b1;
    if ((req_funct3_i == 3'b010) && (req_addr_i[1:0] != 2'b00))
      req_err = 1'b1;
    if ((req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) || (req_funct3_i == 3'b111))
      req_err = 1'b1;
    if (req_we_i && req_funct3_i[2])
      req_err = 1'b1;
    if ({2'b00, req_addr_i[31:2]} >= 32'(RAM_DEPTH))
      req_err = 1'b1;
  end

  always_comb begin
    case (lo_q)
      2'd0:    ld_byte = ram_data_i[7:0];
      2'd1:    ld_byte = ram_data_i[15:8];
      2'd2:    ld_byte = ram_data_i[23:16];
      default: ld_byte = ram_data_i[31:24];
    endcase
    ld_half = lo_q[1] ? ram_data_i[31:16] : ram_data_i[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_ext = {24'h000000, ld_byte};
      3'b101:  load_ext = {16'h0000, ld_half};
      default: load_ext = ram_data_i;
    endcase
  end

  // Only SB and SH reach the merge; f3_q[0] distinguishes them.
  always_comb begin
    merged = ram_data_i;
    if (f3_q[0]) begin
      if (lo_q[1]) merged[31:16] = wdata_q;
      else         merged[15:0]  = wdata_q;
    end else begin
      case (lo_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    lo_d        = lo_q;
    wdata_d     = wdata_q;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    ram_we_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          f3_d    = req_funct3_i;
          lo_d    = req_addr_i[1:0];
          wdata_d = req_wdata_i[15:0];
          if (req_err) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            ram_addr_d = req_addr_i[ADDR_W+1:2];
            if (req_we_i && (req_funct3_i == 3'b010)) begin
              state_d    = S_WR;
              ram_we_d   = 1'b1;
              ram_data_d = req_wdata_i;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD: begin
        if (we_q) begin
          state_d    = S_WR;
          ram_we_d   = 1'b1;
          ram_data_d = merged;
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = load_ext;
        end
      end
      S_WR: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      lo_q        <= 2'b00;
      wdata_q     <= 16'h0;
      ram_addr_q  <= '0;
      ram_data_q  <= 32'h0;
      ram_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      lo_q        <= lo_d;
      wdata_q     <= wdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      ram_we_q    <= ram_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready_o   = ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign ram_address_o = ram_addr_q;
  assign ram_data_o    = ram_data_q;
  assign ram_we_o      = ram_we_q;

endmodule

// File: tb/tb_lsu_ram_master.sv
// Scoreboard bench for lsu_ram_master: directed requests push expected responses,
// a monitor pops and compares data, error flag and response cycle.
module tb_lsu_ram_master;
  localparam int RAM_DEPTH = 512;
  localparam int ADDR_W    = 9;

  logic              clk;
  logic              reset_ni;
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [2:0]        req_funct3_i;
  logic [31:0]       req_addr_i;
  logic [31:0]       req_wdata_i;
  logic              rsp_valid_o;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_err_o;
  logic [ADDR_W-1:0] ram_address_o;
  logic [31:0]       ram_data_o;
  logic              ram_we_o;
  logic [31:0]       ram_data_i;

  lsu_ram_master #(.RAM_DEPTH(RAM_DEPTH)) dut (
    .clk(clk), .reset_ni(reset_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .ram_address_o(ram_address_o), .ram_data_o(ram_data_o),
    .ram_we_o(ram_we_o), .ram_data_i(ram_data_i)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          vecs = 0;
  int          fails = 0;
  int          cyc = 0;
  int          wr_count = 0;
  logic [31:0] mem [RAM_DEPTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  assign ram_data_i = mem[ram_address_o];

  always @(negedge clk) begin
    if (ram_we_o) begin
      mem[ram_address_o] = ram_data_o;
      wr_count = wr_count + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs = vecs + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation, including its cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rsp_valid_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata_o, e.rdata);
          chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, e.err});
          chk("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Latency N means rsp_valid_o is high in the N-th cycle after the accepting edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input bit push, output int acc, output int busy);
    exp_t e;
    @(negedge clk);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    busy = 0;
    while (!req_ready_o && busy < 50) begin
      @(negedge clk);
      busy++;
    end
    if (busy >= 50) chk("accept_timeout", 32'd1, 32'd0);
    acc = cyc + 1;
    if (push) begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.cyc   = acc + lat - 1;
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic drop();
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drain", sb.size(), 32'd0);
    @(negedge clk);
  endtask

  task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                      input int lat);
    int acc, busy;
    issue(we, f3, addr, wdata, exp_rd, exp_err, lat, 1'b1, acc, busy);
    drop();
    wait_done();
  endtask

  initial begin
    int a0, a1, a2, b0, b1, b2, wr_before;
    logic [31:0] m0, m4;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
    a0 = 0; a1 = 0; a2 = 0; b0 = 0; b1 = 0; b2 = 0; wr_before = 0; m0 = 0; m4 = 0;
  end

  initial begin
    int a0, a1, a2, b0, b1, b2, wr_before;
    logic [31:0] m0, m4;
    for (int i = 0; i < RAM_DEPTH; i++) mem[i] = 32'h1000_0000 + i;
    reset_ni = 1'b0;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'b000;
    req_addr_i = 32'h0; req_wdata_i = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err_o}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we_o}, 32'd0);
    chk("rst_ram_addr", {23'd0, ram_address_o}, 32'd0);
    chk("rst_ram_data", ram_data_o, 32'd0);
    reset_ni = 1'b1;

    // Word store then load
    xfer(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    chk("mem4_after_sw", mem[4], 32'hDEADBEEF);
    xfer(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Byte store (RMW) and byte loads
    xfer(1'b1, 3'b000, 32'h11, 32'h00000055, 32'h0, 1'b0, 3);
    chk("mem4_after_sb", mem[4], 32'hDEAD55EF);
    xfer(1'b0, 3'b000, 32'h11, 32'h0, 32'h00000055, 1'b0, 2);
    xfer(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
    xfer(1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2);
    xfer(1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 2);
    xfer(1'b0, 3'b001, 32'h10, 32'h0, 32'h000055EF, 1'b0, 2);

    // Halfword store (RMW) and halfword loads
    xfer(1'b1, 3'b001, 32'h12, 32'h00008001, 32'h0, 1'b0, 3);
    chk("mem4_after_sh", mem[4], 32'h800155EF);
    xfer(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, 2);
    xfer(1'b0, 3'b101, 32'h12, 32'h0, 32'h00008001, 1'b0, 2);
    repeat (3) @(negedge clk);
    chk("rdata_hold", rsp_rdata_o, 32'h00008001);

    // Error cases: one-cycle error response, no RAM write
    wr_before = wr_count;
    m0 = mem[0];
    m4 = mem[4];
    xfer(1'b0, 3'b010, 32'h2,   32'h0,      32'h0, 1'b1, 1);
    xfer(1'b1, 3'b001, 32'h1,   32'h1234,   32'h0, 1'b1, 1);
    xfer(1'b0, 3'b011, 32'h0,   32'h0,      32'h0, 1'b1, 1);
    xfer(1'b0, 3'b010, 32'h800, 32'h0,      32'h0, 1'b1, 1);
    xfer(1'b1, 3'b100, 32'h10,  32'h77,     32'h0, 1'b1, 1);
    xfer(1'b1, 3'b010, 32'h800, 32'hCAFE0000, 32'h0, 1'b1, 1);
    chk("err_no_write", wr_count, wr_before);
    chk("err_mem0", mem[0], m0);
    chk("err_mem4", mem[4], m4);

    // Reset during RD of a byte store aborts it
    wr_before = wr_count;
    issue(1'b1, 3'b000, 32'h10, 32'hAA, 32'h0, 1'b0, 3, 1'b0, a0, b0);
    @(negedge clk);
    reset_ni = 1'b0;
    req_valid_i = 1'b0;
    #1;
    chk("abort_ready", {31'd0, req_ready_o}, 32'd1);
    chk("abort_ram_we", {31'd0, ram_we_o}, 32'd0);
    chk("abort_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    repeat (3) @(negedge clk);
    reset_ni = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_write", wr_count, wr_before);
    chk("abort_mem4", mem[4], 32'h800155EF);

    // Back-to-back loads with req_valid_i held high
    issue(1'b0, 3'b010, 32'h14, 32'h0, 32'h10000005, 1'b0, 2, 1'b1, a0, b0);
    issue(1'b0, 3'b010, 32'h18, 32'h0, 32'h10000006, 1'b0, 2, 1'b1, a1, b1);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h800155EF, 1'b0, 2, 1'b1, a2, b2);
    drop();
    wait_done();
    chk("b2b_spacing1", a1 - a0, 32'd3);
    chk("b2b_spacing2", a2 - a1, 32'd3);
    chk("b2b_ready_low1", b1, 32'd2);
    chk("b2b_ready_low2", b2, 32'd2);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
